fetch_ctrl: RTL and testbench

Instruction-fetch sequencer feeding the decode stage. Owns the fetch PC and issues one read at a time to instruction memory, which may have variable latency. Presents each returned word to decode as insn/pc/insn_valid and holds it while decode stalls. Handles branch/jump redirects by discarding stale in-flight fetches.

---
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer that issues one read at a time and presents words to decode
//
// Ports:
//   clock           in   rising-edge system clock
//   reset           in   synchronous active-high reset
//   mem_addr        out  [31:0] word-aligned instruction memory read address
//   mem_rd_en       out  one-cycle read request pulse
//   mem_rdata       in   [31:0] word returned by memory
//   mem_rdata_valid in   mem_rdata valid this cycle
//   insn            out  [31:0] instruction word to decode
//   pc              out  [31:0] address of insn
//   insn_valid      out  insn/pc valid for decode
//   decode_stall    in   decode cannot accept this cycle
//   redirect_valid  in   branch/jump taken, refetch from redirect_pc
//   redirect_pc     in   [31:0] new fetch address (two LSBs ignored)
//   insn_count      out  [COUNT_W-1:0] instructions accepted by decode
//
// Optional feature macro: FETCH_TRACE_EN prints accepted instructions and redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80020000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic [31:0]        mem_addr,
  output logic               mem_rd_en,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rdata_valid,
  output logic [31:0]        insn,
  output logic [31:0]        pc,
  output logic               insn_valid,
  input  logic               decode_stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [COUNT_W-1:0] insn_count
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, DRAIN} state_t;
  state_t             r_state, w_state_nxt;
  logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]        r_mem_addr;
  logic               r_mem_rd_en;
  logic [31:0]        r_insn, w_insn_nxt;
  logic [31:0]        r_pc, w_pc_nxt;
  logic               r_insn_valid, w_insn_valid_nxt;
  logic               w_accept;
  logic [COUNT_W-1:0] r_count;
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_insn_nxt       = r_insn;
    w_pc_nxt         = r_pc;
    w_insn_valid_nxt = r_insn_valid;
    w_accept         = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ:     w_state_nxt = WAIT;
      WAIT: begin
        if (mem_rdata_valid) begin
          w_state_nxt      = PRESENT;
          w_insn_nxt       = mem_rdata;
          w_pc_nxt         = r_fetch_pc;
          w_insn_valid_nxt = 1'b1;
        end
      end
      PRESENT: begin
        if (!decode_stall) begin
          w_state_nxt      = REQ;
          w_fetch_pc_nxt   = r_fetch_pc + 32'd4;
          w_insn_valid_nxt = 1'b0;
          w_accept         = 1'b1;
        end
      end
      DRAIN:   w_state_nxt = mem_rdata_valid ? REQ : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
    // A redirect overrides everything; a request still in flight must be drained first.
    if (redirect_valid) begin
      w_fetch_pc_nxt   = {redirect_pc[31:2], 2'b00};
      w_insn_nxt       = r_insn;
      w_pc_nxt         = r_pc;
      w_insn_valid_nxt = 1'b0;
      w_accept         = 1'b0;
      w_state_nxt      = (r_state == REQ || ((r_state == WAIT || r_state == DRAIN) && !mem_rdata_valid)) ? DRAIN : REQ;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_mem_addr   <= RESET_PC;
      r_mem_rd_en  <= 1'b0;
      r_insn       <= 32'd0;
      r_pc         <= RESET_PC;
      r_insn_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_mem_rd_en  <= (w_state_nxt == REQ);
      r_mem_addr   <= (w_state_nxt == REQ) ? w_fetch_pc_nxt : r_mem_addr;
      r_insn       <= w_insn_nxt;
      r_pc         <= w_pc_nxt;
      r_insn_valid <= w_insn_valid_nxt;
      r_count      <= w_accept ? r_count + COUNT_W'(1) : r_count;
    end
  end
`ifdef FETCH_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && w_accept) $display("FETCH pc: %h insn: %h", r_pc, r_insn);
    if (!reset && redirect_valid) $display("REDIRECT from %h to %h", r_fetch_pc, w_fetch_pc_nxt);
  end
`else
`endif
  assign mem_addr   = r_mem_addr;
  assign mem_rd_en  = r_mem_rd_en;
  assign insn       = r_insn;
  assign pc         = r_pc;
  assign insn_valid = r_insn_valid;
  assign insn_count = r_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plus random checks of fetch_ctrl against a transaction-level scoreboard
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h80020000;
  localparam int          CW       = 4;
  logic          clock = 0, reset = 1, mem_rdata_valid = 0, decode_stall = 0, redirect_valid = 0;
  logic [31:0]   mem_rdata = 0, redirect_pc = 0;
  logic [31:0]   mem_addr, insn, pc;
  logic          mem_rd_en, insn_valid;
  logic [CW-1:0] insn_count;
  fetch_ctrl #(.RESET_PC(RESET_PC), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .insn(insn), .pc(pc),
    .insn_valid(insn_valid), .decode_stall(decode_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .insn_count(insn_count)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0, cyc = 0, idle = 0, cnt = 0, nval = 0, t = 0;
  int p_stall = 0, p_redir = 0, lat_min = 1, lat_max = 1;
  logic do_reset = 1, force_stall = 0, force_redir = 0;
  logic armed = 0, prev_reset = 0, prev_valid = 0, prev_stall = 0, prev_redir = 0, live = 0, outstanding = 0;
  logic [31:0] force_pc = 0, exp_addr = RESET_PC, last_req = 0, mem_req = 0, prev_insn = 0, prev_pc = 0;
  logic [CW-1:0] exp_count = 0;
  int rd_cyc[$];
  logic [31:0] rd_addr[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8002000C) ? 32'h8C220004 : (a ^ 32'h5EED1234) + {a[15:0], a[31:16]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    @(negedge clock);
    cyc++;
    if (armed) begin
      if (prev_reset) begin
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", mem_addr, RESET_PC);
        chk("rst_insn", insn, 0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_valid", 32'(insn_valid), 0);
        chk("rst_count", 32'(insn_count), 0);
      end else begin
        if (mem_rd_en) begin
          chk("req_overlap", 32'(outstanding), 0);
          chk("req_addr", mem_addr, exp_addr);
        end
        if (insn_valid) begin
          chk("pres_pc", pc, last_req);
          chk("pres_live", 32'(live), 1);
          chk("pres_insn", insn, mem_word(pc));
        end
        if (prev_valid && prev_stall && !prev_redir) begin
          chk("hold_valid", 32'(insn_valid), 1);
          chk("hold_insn", insn, prev_insn);
          chk("hold_pc", pc, prev_pc);
        end
        if (prev_redir || (prev_valid && !prev_stall)) chk("drop_valid", 32'(insn_valid), 0);
        chk("count", 32'(insn_count), 32'(exp_count));
        chk("watchdog", 32'(idle < 64), 1);
      end
    end
    if (armed && mem_rd_en === 1'b1) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(mem_addr);
      last_req = mem_addr;
      mem_req = mem_addr;
      live = 1;
      outstanding = 1;
      cnt = $urandom_range(lat_max, lat_min);
      mem_rdata_valid = 0;
      idle = 0;
    end else begin
      idle++;
      mem_rdata_valid = 0;
      if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          mem_rdata_valid = 1;
          mem_rdata = mem_word(mem_req);
          outstanding = 0;
        end
      end
    end
    if (!mem_rdata_valid) mem_rdata = $urandom;
    reset = do_reset;
    decode_stall = force_stall || ($urandom_range(99, 0) < p_stall);
    redirect_valid = force_redir || ($urandom_range(99, 0) < p_redir);
    redirect_pc = force_redir ? force_pc : $urandom;
    if (reset) begin
      armed = 1;
      prev_reset = 1;
      exp_addr = RESET_PC;
      exp_count = 0;
      live = 0;
      outstanding = 0;
      mem_rdata_valid = 0;
      prev_valid = 0;
      prev_stall = 0;
      prev_redir = 0;
      idle = 0;
    end else begin
      prev_reset = 0;
      if (redirect_valid) begin
        exp_addr = {redirect_pc[31:2], 2'b00};
        live = 0;
      end else if (insn_valid === 1'b1 && !decode_stall) begin
        exp_addr = last_req + 32'd4;
        exp_count++;
      end
      prev_valid = (insn_valid === 1'b1);
      prev_stall = decode_stall;
      prev_redir = redirect_valid;
      prev_insn = insn;
      prev_pc = pc;
    end
  endtask
  initial begin
    step();
    step();
    do_reset = 0;
    rd_cyc.delete();
    rd_addr.delete();
    for (int i = 0; i < 40 && insn_count !== 4'd3; i++) step();
    chk("t1_count", 32'(insn_count), 3);
    chk("t1_nreq", 32'(rd_addr.size() >= 3), 1);
    chk("t1_addr0", rd_addr[0], 32'h80020000);
    chk("t1_addr1", rd_addr[1], 32'h80020004);
    chk("t1_addr2", rd_addr[2], 32'h80020008);
    chk("t1_gap01", rd_cyc[1] - rd_cyc[0], 3);
    chk("t1_gap12", rd_cyc[2] - rd_cyc[1], 3);
    force_stall = 1;
    for (int i = 0; i < 20 && insn_valid !== 1'b1; i++) step();
    chk("t2_insn", insn, 32'h8C220004);
    chk("t2_pc", pc, 32'h8002000C);
    repeat (4) step();
    chk("t2_count_held", 32'(insn_count), 3);
    force_stall = 0;
    step();
    chk("t2_valid6", 32'(insn_valid), 1);
    chk("t2_insn6", insn, 32'h8C220004);
    chk("t2_count6", 32'(insn_count), 3);
    lat_min = 4;
    lat_max = 4;
    step();
    chk("t2_count_rel", 32'(insn_count), 4);
    chk("t3_req", 32'(mem_rd_en), 1);
    force_redir = 1;
    force_pc = 32'h80020103;
    step();
    force_redir = 0;
    lat_min = 1;
    lat_max = 1;
    t = cyc;
    nval = 0;
    for (int i = 0; i < 20 && mem_rd_en !== 1'b1; i++) begin
      step();
      if (insn_valid === 1'b1) nval++;
    end
    chk("t3_addr", mem_addr, 32'h80020100);
    chk("t3_valid", nval, 0);
    chk("t3_delay", cyc - t, 4);
    force_redir = 1;
    force_pc = 32'h80020200;
    step();
    force_redir = 0;
    step();
    chk("t4_rd_en", 32'(mem_rd_en), 1);
    chk("t4_addr", mem_addr, 32'h80020200);
    chk("t4_valid", 32'(insn_valid), 0);
    force_redir = 1;
    force_pc = 32'hFFFFFFFF;
    step();
    force_redir = 0;
    step();
    chk("t5_rd_en", 32'(mem_rd_en), 1);
    chk("t5_addr", mem_addr, 32'hFFFFFFFC);
    for (int i = 0; i < 20 && insn_valid !== 1'b1; i++) step();
    chk("t5_pc", pc, 32'hFFFFFFFC);
    step();
    chk("t5_wrap_rd_en", 32'(mem_rd_en), 1);
    chk("t5_wrap_addr", mem_addr, 32'h00000000);
    for (int i = 0; i < 80 && insn_count !== 4'hF; i++) step();
    chk("t5_c15", 32'(insn_count), 15);
    for (int i = 0; i < 10 && insn_count === 4'hF; i++) step();
    chk("t5_cwrap", 32'(insn_count), 0);
    force_stall = 1;
    for (int i = 0; i < 20 && insn_valid !== 1'b1; i++) step();
    chk("t6_valid", 32'(insn_valid), 1);
    do_reset = 1;
    step();
    do_reset = 0;
    force_stall = 0;
    step();
    chk("t6_valid0", 32'(insn_valid), 0);
    chk("t6_addr", mem_addr, RESET_PC);
    chk("t6_count", 32'(insn_count), 0);
    step();
    chk("t6_rd_en", 32'(mem_rd_en), 1);
    chk("t6_refetch", mem_addr, RESET_PC);
    p_stall = 30;
    p_redir = 6;
    lat_min = 1;
    lat_max = 5;
    repeat (3000) begin
      do_reset = ($urandom_range(499, 0) == 0);
      step();
    end
    do_reset = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
